// File: rtl/usr_pkg.sv
// Shared constants for the universal shift register: mode select width and encodings.
package usr_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b101;
  localparam logic [MODE_W-1:0] MODE_UP   = 3'b110;
  localparam logic [MODE_W-1:0] MODE_DN   = 3'b111;

endpackage

// File: rtl/universal_shift_register.sv
// WIDTH-bit storage/shift/count element with async clear, sync preset, enable,
// eight operating modes and a registered terminal-count pulse on counter wrap.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] PRESET_VALUE = {WIDTH{1'b1}}
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              preset,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin_r,
  input  logic              sin_l,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  q_bar,
  output logic              sout_r,
  output logic              sout_l,
  output logic              zero,
  output logic              tc
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of q, regardless of statement order.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      q  <= '0;
      tc <= 1'b0;
    end else if (!preset) begin
      q  <= PRESET_VALUE;
      tc <= 1'b0;
    end else if (!en) begin
      tc <= 1'b0;
    end else begin
      tc <= 1'b0;
      case (mode)
        MODE_SHR:  q <= {sin_r, q[WIDTH-1:1]};
        MODE_SHL:  q <= {q[WIDTH-2:0], sin_l};
        MODE_ROR:  q <= {q[0], q[WIDTH-1:1]};
        MODE_ROL:  q <= {q[WIDTH-2:0], q[WIDTH-1]};
        MODE_LOAD: q <= d;
        MODE_UP: begin
          q  <= q + WIDTH'(1);
          tc <= &q;
        end
        MODE_DN: begin
          q  <= q - WIDTH'(1);
          tc <= ~|q;
        end
        default:   q <= q;
      endcase
    end
  end

  // Derived outputs follow q with no added latency.
  assign q_bar  = ~q;
  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];
  assign zero   = (q == '0);

endmodule
